level_hazard_ctrl: RTL and testbench

Responder to the level state machine: it executes "open pit 1 / open pit 2 / raise spikes / restart" requests by animating the hazard geometry over time. It also watches the player box against that geometry and reports death back to the level state machine. It sits between the level FSM, the player physics block that supplies `x_pos` and `y_pos`, and the VGA renderer, which draws the pits and spikes from its outputs.

---
 rtl/level_pkg.sv | 40 ++++
 rtl/step_ticker.sv | 38 +++
 rtl/level_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_level_hazard_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
`default_nettype none
// level_pkg: shared screen constants, FSM state encoding and request priority for the level hazard logic.
package level_pkg;

  localparam int COORD_W = 10;
  localparam int FLOOR_Y = 400;
  localparam int FALL_Y  = 470;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ANIM_P1 = 3'd1,
    ST_ANIM_P2 = 3'd2,
    ST_ANIM_SP = 3'd3,
    ST_DEAD    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    REQ_NONE    = 3'd0,
    REQ_RESTART = 3'd1,
    REQ_PIT1    = 3'd2,
    REQ_PIT2    = 3'd3,
    REQ_SPIKES  = 3'd4
  } req_e;

  // Restart beats every animation request; lower strobes in the same cycle are dropped.
  function automatic req_e req_decode(input logic restart, input logic pit1,
                                      input logic pit2, input logic spikes);
    if (restart)     return REQ_RESTART;
    else if (pit1)   return REQ_PIT1;
    else if (pit2)   return REQ_PIT2;
    else if (spikes) return REQ_SPIKES;
    else             return REQ_NONE;
  endfunction

  function automatic int ticker_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_ticker.sv
`default_nettype none
// step_ticker: animation prescaler counting 0..STEP_DIV-1; tick is high in the cycle that wraps.
module step_ticker
  import level_pkg::*;
#(
  parameter int STEP_DIV = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = ticker_width(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/level_hazard_ctrl.sv
`default_nettype none
// level_hazard_ctrl: animates pits/spikes on level-FSM request and flags player death.
// Optional spike hazard compiled in with HAZARD_SPIKES_EN.
module level_hazard_ctrl #(
  parameter int COORD_W     = level_pkg::COORD_W,
  parameter int STEP_DIV    = 500000,
  parameter int STEP_PX     = 2,
  parameter int PIT1_MAX_W  = 64,
  parameter int PIT2_MAX_W  = 96,
  parameter int PIT1_X      = 200,
  parameter int PIT2_X      = 400,
  parameter int SPIKE_X     = 520,
  parameter int SPIKE_W     = 32,
  parameter int SPIKE_MAX_H = 24,
  parameter int FLOOR_Y     = level_pkg::FLOOR_Y,
  parameter int FALL_Y      = level_pkg::FALL_Y,
  parameter int PLAYER_W    = 16,
  parameter int PLAYER_H    = 16
) (
  input  logic               Clk,
  input  logic               reset_n,
  input  logic               open_pit1,
  input  logic               open_pit2,
  input  logic               raise_spikes,
  input  logic               level_restart,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  output logic [COORD_W-1:0] pit1_w,
  output logic [COORD_W-1:0] pit2_w,
  output logic [COORD_W-1:0] spike_h,
  output logic               anim_busy,
  output logic               anim_done,
  output logic               death
);

  import level_pkg::*;

  localparam int CW = COORD_W + 1;
  localparam logic [COORD_W-1:0] C_P1_MAX = COORD_W'(PIT1_MAX_W);
  localparam logic [COORD_W-1:0] C_P2_MAX = COORD_W'(PIT2_MAX_W);

  // Pit x positions are renderer-only; kept as parameters so both sides share one source.
  localparam int C_PIT_X_SUM = PIT1_X + PIT2_X;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] pit1_q, pit1_d, pit2_q, pit2_d;
  logic               busy_q, busy_d, done_q, done_d, death_q, death_d;
  logic               tick, tick_clr, tick_en;
  req_e               req;
  logic [COORD_W:0]   y_bot, x_right, spike_top;
  logic [COORD_W-1:0] pit1_next, pit2_next;
  logic               fall_hit, spike_hit, hit;

  function automatic logic [COORD_W-1:0] step_geom(input logic [COORD_W-1:0] cur,
                                                   input logic [COORD_W-1:0] max_v);
    logic [COORD_W:0] sum;
    sum = {1'b0, cur} + CW'(STEP_PX);
    if (sum >= {1'b0, max_v})
      return max_v;
    else
      return sum[COORD_W-1:0];
  endfunction

  assign req       = req_decode(level_restart, open_pit1, open_pit2, raise_spikes);
  assign pit1_next = step_geom(pit1_q, C_P1_MAX);
  assign pit2_next = step_geom(pit2_q, C_P2_MAX);

  assign y_bot     = {1'b0, y_pos} + CW'(PLAYER_H);
  assign x_right   = {1'b0, x_pos} + CW'(PLAYER_W);
  assign spike_top = CW'(FLOOR_Y) - {1'b0, spike_h};
  assign fall_hit  = (y_bot >= CW'(FALL_Y));
  // With spikes compiled out spike_h is constant zero, so this term folds away.
  assign spike_hit = (spike_h != '0) && (x_right > CW'(SPIKE_X)) &&
                     ({1'b0, x_pos} < CW'(SPIKE_X + SPIKE_W)) && (y_bot > spike_top);
  assign hit       = (fall_hit || spike_hit) && (C_PIT_X_SUM >= 0);

  assign tick_en = (state_q == ST_ANIM_P1) || (state_q == ST_ANIM_P2) ||
                   (state_q == ST_ANIM_SP);

  step_ticker #(
    .STEP_DIV (STEP_DIV)
  ) u_ticker (
    .clk   (Clk),
    .rst_n (reset_n),
    .clr   (tick_clr),
    .en    (tick_en),
    .tick  (tick)
  );

`ifdef HAZARD_SPIKES_EN
  localparam logic [COORD_W-1:0] C_SP_MAX = COORD_W'(SPIKE_MAX_H);
  logic [COORD_W-1:0] spike_q, spike_d, spike_next;
  assign spike_next = step_geom(spike_q, C_SP_MAX);
  assign spike_h    = spike_q;
`else
  assign spike_h = '0;
`endif

  always_comb begin
    state_d  = state_q;
    pit1_d   = pit1_q;
    pit2_d   = pit2_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    death_d  = death_q;
    tick_clr = 1'b0;
`ifdef HAZARD_SPIKES_EN
    spike_d  = spike_q;
`endif
    if (req == REQ_RESTART) begin
      state_d  = ST_IDLE;
      pit1_d   = '0;
      pit2_d   = '0;
      busy_d   = 1'b0;
      death_d  = 1'b0;
      tick_clr = 1'b1;
`ifdef HAZARD_SPIKES_EN
      spike_d  = '0;
`endif
    end else if ((state_q != ST_DEAD) && hit) begin
      state_d = ST_DEAD;
      death_d = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          case (req)
            REQ_PIT1: begin
              state_d  = ST_ANIM_P1;
              busy_d   = 1'b1;
              tick_clr = 1'b1;
            end
            REQ_PIT2: begin
              state_d  = ST_ANIM_P2;
              busy_d   = 1'b1;
              tick_clr = 1'b1;
            end
            REQ_SPIKES: begin
`ifdef HAZARD_SPIKES_EN
              state_d  = ST_ANIM_SP;
              busy_d   = 1'b1;
              tick_clr = 1'b1;
`else
              done_d   = 1'b1;
`endif
            end
            default: ;
          endcase
        end
        ST_ANIM_P1: begin
          if (tick) begin
            pit1_d = pit1_next;
            if (pit1_next == C_P1_MAX) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        ST_ANIM_P2: begin
          if (tick) begin
            pit2_d = pit2_next;
            if (pit2_next == C_P2_MAX) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
`ifdef HAZARD_SPIKES_EN
        ST_ANIM_SP: begin
          if (tick) begin
            spike_d = spike_next;
            if (spike_next == C_SP_MAX) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
`endif
        ST_DEAD: ;
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pit1_q  <= '0;
      pit2_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      death_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pit1_q  <= pit1_d;
      pit2_q  <= pit2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      death_q <= death_d;
    end
  end

`ifdef HAZARD_SPIKES_EN
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)
      spike_q <= '0;
    else
      spike_q <= spike_d;
  end
`endif

  assign pit1_w    = pit1_q;
  assign pit2_w    = pit2_q;
  assign anim_busy = busy_q;
  assign anim_done = done_q;
  assign death     = death_q;

endmodule
`default_nettype wire

// File: tb/tb_level_hazard_ctrl.sv
`default_nettype none
// tb_level_hazard_ctrl: directed bench with STEP_DIV=4, STEP_PX=2, PIT1_MAX_W=8, PIT2_MAX_W=12.
module tb_level_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       open_pit1 = 1'b0, open_pit2 = 1'b0, raise_spikes = 1'b0, level_restart = 1'b0;
  logic [9:0] x_pos = 10'd0, y_pos = 10'd300;
  logic [9:0] pit1_w, pit2_w, spike_h;
  logic       anim_busy, anim_done, death;

  int n_pass  = 0;
  int n_total = 0;

  level_hazard_ctrl #(
    .STEP_DIV   (4),
    .STEP_PX    (2),
    .PIT1_MAX_W (8),
    .PIT2_MAX_W (12)
  ) dut (
    .Clk           (Clk),
    .reset_n       (reset_n),
    .open_pit1     (open_pit1),
    .open_pit2     (open_pit2),
    .raise_spikes  (raise_spikes),
    .level_restart (level_restart),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .pit1_w        (pit1_w),
    .pit2_w        (pit2_w),
    .spike_h       (spike_h),
    .anim_busy     (anim_busy),
    .anim_done     (anim_done),
    .death         (death)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/pit1_w"},    32'(pit1_w),    0);
    check({tag, "/pit2_w"},    32'(pit2_w),    0);
    check({tag, "/spike_h"},   32'(spike_h),   0);
    check({tag, "/anim_busy"}, 32'(anim_busy), 0);
    check({tag, "/anim_done"}, 32'(anim_done), 0);
    check({tag, "/death"},     32'(death),     0);
  endtask

  task automatic restart();
    level_restart = 1'b1;
    step();
    level_restart = 1'b0;
  endtask

  initial begin
    int done_seen;

    // reset
    step();
    step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();
    check_all_zero("post_reset");

    // single pit1 animation
    open_pit1 = 1'b1;
    step();
    open_pit1 = 1'b0;
    check("p1_accept_busy", 32'(anim_busy), 1);
    check("p1_accept_w", 32'(pit1_w), 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("p1_w_k%0d", k), 32'(pit1_w), 2 * (k / 4));
      check($sformatf("p1_busy_k%0d", k), 32'(anim_busy), (k < 16) ? 1 : 0);
      check($sformatf("p1_done_k%0d", k), 32'(anim_done), (k == 16) ? 1 : 0);
    end
    step();
    check("p1_done_pulse_end", 32'(anim_done), 0);
    check("p1_hold", 32'(pit1_w), 8);

    // pit1 + pit2 together, plus pit2 during ANIM_P1
    restart();
    check_all_zero("restart1");
    open_pit1 = 1'b1;
    open_pit2 = 1'b1;
    step();
    open_pit1 = 1'b0;
    open_pit2 = 1'b0;
    check("prio_busy", 32'(anim_busy), 1);
    for (int k = 1; k <= 16; k++) begin
      open_pit2 = (k == 5);
      step();
      check($sformatf("prio_p2_k%0d", k), 32'(pit2_w), 0);
    end
    open_pit2 = 1'b0;
    check("prio_p1_final", 32'(pit1_w), 8);
    check("prio_done", 32'(anim_done), 1);
    for (int k = 0; k < 8; k++) step();
    check("prio_p2_after", 32'(pit2_w), 0);
    check("prio_busy_after", 32'(anim_busy), 0);

    // restart mid-animation, then immediate reaccept
    restart();
    open_pit1 = 1'b1;
    step();
    open_pit1 = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check("mid_p1_w4", 32'(pit1_w), 4);
    restart();
    check("mid_restart_w", 32'(pit1_w), 0);
    check("mid_restart_busy", 32'(anim_busy), 0);
    open_pit1 = 1'b1;
    step();
    open_pit1 = 1'b0;
    check("reaccept_busy", 32'(anim_busy), 1);
    for (int k = 0; k < 4; k++) step();
    check("reaccept_w", 32'(pit1_w), 2);
    restart();
    check_all_zero("restart2");

    // fall boundary: 453+16=469 is safe
    y_pos = 10'd453;
    step();
    check("fall_469_safe", 32'(death), 0);
    y_pos = 10'd300;

    // death during ANIM_P2
    open_pit2 = 1'b1;
    step();
    open_pit2 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("p2_w2", 32'(pit2_w), 2);
    y_pos = 10'd454;
    step();
    check("fall_death", 32'(death), 1);
    check("fall_busy", 32'(anim_busy), 0);
    check("fall_p2_frozen", 32'(pit2_w), 2);
    y_pos = 10'd300;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      open_pit1 = (k == 10);
      step();
      if (anim_done) done_seen++;
    end
    open_pit1 = 1'b0;
    check("dead_hold", 32'(death), 1);
    check("dead_p2_frozen", 32'(pit2_w), 2);
    check("dead_p1_ignored", 32'(pit1_w), 0);
    check("dead_no_done", 32'(done_seen), 0);
    restart();
    check_all_zero("restart_dead");

`ifdef HAZARD_SPIKES_EN
    raise_spikes = 1'b1;
    step();
    raise_spikes = 1'b0;
    check("sp_busy", 32'(anim_busy), 1);
    for (int k = 1; k <= 48; k++) step();
    check("sp_full", 32'(spike_h), 24);
    check("sp_done", 32'(anim_done), 1);
    x_pos = 10'd500;
    y_pos = 10'd370;
    step();
    check("sp_no_overlap", 32'(death), 0);
    x_pos = 10'd510;
    step();
    check("sp_death", 32'(death), 1);
    x_pos = 10'd0;
    y_pos = 10'd300;
    restart();
    check_all_zero("restart_sp");
`else
    raise_spikes = 1'b1;
    step();
    raise_spikes = 1'b0;
    check("nsp_done", 32'(anim_done), 1);
    check("nsp_busy", 32'(anim_busy), 0);
    check("nsp_h", 32'(spike_h), 0);
    step();
    check("nsp_done_end", 32'(anim_done), 0);
    check("nsp_busy_end", 32'(anim_busy), 0);
    x_pos = 10'd510;
    y_pos = 10'd370;
    step();
    check("nsp_no_spike_death", 32'(death), 0);
    x_pos = 10'd0;
    y_pos = 10'd300;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
